// File: rtl/fifo_sync_param.sv
// ----------------------------------------------------------------------------
// fifo_sync_param
//
// Single-clock parametrised FIFO used as a rate-smoothing buffer between
// producer and consumer stages that share one clock. It provides an occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow
// flags. It also defines behaviour for a simultaneous read and write when the
// FIFO is empty or full.
//
// Parameters:
//   DATA_W   - data word width in bits (>= 1)
//   DEPTH    - number of entries, power of two (>= 2)
//   AF_LEVEL - almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL - almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   wr           in   write request (accepted when not full)
//   rd           in   read request (accepted when not empty)
//   data_in      in   write data, sampled when a write is accepted
//   err_clr      in   synchronous clear of overflow/underflow
//   data_out     out  read data (registered)
//   empty        out  no entries stored
//   full         out  DEPTH entries stored
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  occupancy 0..DEPTH
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//
// Build option:
//   FIFO_FWFT_EN - when defined, the FIFO is first-word-fall-through. data_out
//                  presents the head word whenever the FIFO is not empty, and
//                  it is 0 while the FIFO is empty. rd acknowledges and pops
//                  the head word. When the macro is undefined, a read returns
//                  registered data one cycle after it is accepted.
// ----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LEVEL);

    // Storage. It is deliberately left unreset; the pointers define validity.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // The pointers carry one extra MSB, which acts as a wrap bit.
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wr_acc_s;
    logic              rd_acc_s;

    // Acceptance decisions use only the registered (pre-edge) status.
    assign wr_acc_s = wr & ~full_q;
    assign rd_acc_s = rd & ~empty_q;

    // Next-state for pointers, occupancy, status flags and sticky errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // The FIFO is empty when the pointers are identical. It is full when
        // only the wrap bits differ.
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                  (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
        af_d    = (count_d >= AF_CNT);
        ae_d    = (count_d <= AE_CNT);

        // A new error takes priority over err_clr in the same cycle.
        if (wr && full_q) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (rd && empty_q) begin
            udf_d = 1'b1;
        end else if (err_clr) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head-word presentation: the output register is loaded with the word
    // that will be at the head after this edge. That word is forwarded from
    // data_in when it is being written into the slot that becomes the head.
    always_comb begin
        dout_d = dout_q;
        if (empty_d) begin
            dout_d = {DATA_W{1'b0}};
        end else if (wr_acc_s && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0])) begin
            dout_d = data_in;
        end else begin
            dout_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
        end
    end
`else
    // Registered read: an accepted read loads the head word. Otherwise the
    // output register holds its value.
    always_comb begin
        dout_d = dout_q;
        if (rd_acc_s) begin
            dout_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end else begin
            dout_d = dout_q;
        end
    end
`endif

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            dout_q   <= {DATA_W{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign data_out     = dout_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
